// File: rtl/midi_pkg.sv
// Shared MIDI parser types, status constants and length helper.
// Imported by the byte parser and the status logic.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    SYSEX = 2'd2
  } state_t;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] ST_TUNE  = 8'hF6;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  function automatic logic [1:0] data_len(
    input logic [7:0] s
  );
    logic [1:0] n;
    n = 2'd0;
    if (s[7:4] == 4'hC || s[7:4] == 4'hD)
      n = 2'd1;
    else if (s[7] && s[7:4] != 4'hF)
      n = 2'd2;
    else if (s == 8'hF1 || s == 8'hF3)
      n = 2'd1;
    else if (s == 8'hF2)
      n = 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte framer: rx bytes -> status/index/data bundle.
// In: reg_clk, reg_reset, rx_valid, rx_byte. Out: byteready bundle, msg_done, rt_*, sysex_active, err_count.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             reg_clk,
  input  logic             reg_reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic             byteready,
  output logic [7:0]       cur_status,
  output logic [7:0]       midibyte_nr,
  output logic [7:0]       midi_in_data,
  output logic             msg_done,
  output logic             rt_valid,
  output logic [7:0]       rt_byte,
  output logic             sysex_active,
  output logic [ERR_W-1:0] err_count
);

  state_t     state, state_n;
  logic [1:0] need, need_n;
  logic [7:0] idx, idx_n;
  logic       sys_com, sys_com_n;
  logic       clr, clr_n;
  logic [7:0] cs_n, nr_n, dat_n, rb_n;
  logic       br_n, md_n, rv_n;
  logic [1:0] err_inc;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_n;

  logic [7:0] idx_inc, idx_sat;
  logic       is_rt, is_data, is_eox, is_stat;

  assign idx_inc = idx + 8'd1;
  assign idx_sat = (idx == 8'hFF) ? 8'hFF : idx_inc;

  assign is_rt   = rx_byte >= RT_MIN;
  assign is_data = !rx_byte[7];
  assign is_eox  = rx_byte == ST_EOX;
  assign is_stat = rx_byte[7] && !is_rt && !is_eox;

  assign sysex_active = (state == SYSEX);

  assign err_sum = {1'b0, err_count}
                 + {{(ERR_W-1){1'b0}}, err_inc};
  assign err_n = err_sum[ERR_W] ? {ERR_W{1'b1}}
                                : err_sum[ERR_W-1:0];

  always_comb begin
    state_n   = state;
    need_n    = need;
    idx_n     = idx;
    sys_com_n = sys_com;
    clr_n     = 1'b0;
    // a finished system message drops its status
    // one cycle after the last byte was shown
    cs_n      = clr ? 8'h00 : cur_status;
    nr_n      = midibyte_nr;
    dat_n     = midi_in_data;
    rb_n      = rt_byte;
    br_n      = 1'b0;
    md_n      = 1'b0;
    rv_n      = 1'b0;
    err_inc   = 2'd0;
    if (rx_valid) begin
      unique case (1'b1)
        is_rt: begin
          rv_n = 1'b1;
          rb_n = rx_byte;
        end
        is_data: begin
          unique case (state)
            SYSEX: begin
              idx_n = idx_sat;
              nr_n  = idx_sat;
              dat_n = rx_byte;
              br_n  = 1'b1;
            end
            DATA: begin
              nr_n  = idx_inc;
              dat_n = rx_byte;
              br_n  = 1'b1;
              idx_n = idx_inc;
              if (idx_inc == {6'd0, need}) begin
                md_n  = 1'b1;
                idx_n = 8'd0;
                if (sys_com) begin
                  clr_n   = 1'b1;
                  state_n = IDLE;
                end
              end
            end
            default: err_inc = 2'd1;
          endcase
        end
        is_eox: begin
          if (state == SYSEX) begin
            nr_n    = idx_sat;
            dat_n   = rx_byte;
            br_n    = 1'b1;
            md_n    = 1'b1;
            clr_n   = 1'b1;
            idx_n   = 8'd0;
            state_n = IDLE;
          end else begin
            err_inc = 2'd1;
          end
        end
        is_stat: begin
          // status inside SysEx ends it implicitly
          err_inc = (state == SYSEX) ? 2'd1 : 2'd0;
          idx_n   = 8'd0;
          if (rx_byte == 8'hF4 || rx_byte == 8'hF5) begin
            err_inc = err_inc + 2'd1;
            cs_n    = 8'h00;
            state_n = IDLE;
          end else begin
            cs_n  = rx_byte;
            nr_n  = 8'd0;
            dat_n = rx_byte;
            br_n  = 1'b1;
            if (rx_byte == ST_TUNE) begin
              md_n    = 1'b1;
              clr_n   = 1'b1;
              state_n = IDLE;
            end else if (rx_byte == ST_SYSEX) begin
              state_n = SYSEX;
            end else begin
              need_n    = data_len(rx_byte);
              sys_com_n = rx_byte[7:4] == 4'hF;
              state_n   = DATA;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge reg_clk or posedge reg_reset) begin
    if (reg_reset) begin
      state        <= IDLE;
      need         <= 2'd0;
      idx          <= 8'd0;
      sys_com      <= 1'b0;
      clr          <= 1'b0;
      cur_status   <= 8'h00;
      midibyte_nr  <= 8'h00;
      midi_in_data <= 8'h00;
      rt_byte      <= 8'h00;
      byteready    <= 1'b0;
      msg_done     <= 1'b0;
      rt_valid     <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_n;
      need         <= need_n;
      idx          <= idx_n;
      sys_com      <= sys_com_n;
      clr          <= clr_n;
      cur_status   <= cs_n;
      midibyte_nr  <= nr_n;
      midi_in_data <= dat_n;
      rt_byte      <= rb_n;
      byteready    <= br_n;
      msg_done     <= md_n;
      rt_valid     <= rv_n;
      err_count    <= err_n;
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Randomized + directed bench for midi_byte_parser.
// Reference model tracks message framing with plain integers.
module tb_midi_byte_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       byteready, msg_done, rt_valid, sysex_active;
  logic [7:0] cur_status, midibyte_nr, midi_in_data, rt_byte;
  logic [7:0] err_count;

  midi_byte_parser #(.ERR_W(8)) dut (
    .reg_clk     (clk),
    .reg_reset   (rst),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .byteready   (byteready),
    .cur_status  (cur_status),
    .midibyte_nr (midibyte_nr),
    .midi_in_data(midi_in_data),
    .msg_done    (msg_done),
    .rt_valid    (rt_valid),
    .rt_byte     (rt_byte),
    .sysex_active(sysex_active),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int md_seen = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: 0 = no status, 1 = collecting, 2 = in sysex
  int mode, len, pos, err;
  bit syscom, pend;
  int e_br, e_md, e_rv, e_rb, e_cs, e_nr, e_dat;

  task automatic model_reset();
    mode = 0; len = 0; pos = 0; err = 0;
    syscom = 0; pend = 0;
    e_br = 0; e_md = 0; e_rv = 0; e_rb = 0;
    e_cs = 0; e_nr = 0; e_dat = 0;
  endtask

  task automatic bump();
    if (err < 255) err++;
  endtask

  task automatic emit(int cs, int nr, int d);
    e_br = 1; e_cs = cs; e_nr = nr; e_dat = d;
  endtask

  task automatic model_step(bit v, int b);
    e_br = 0; e_md = 0; e_rv = 0;
    if (pend) begin e_cs = 0; pend = 0; end
    if (!v) return;
    if (b >= 'hF8) begin
      e_rv = 1; e_rb = b;
    end else if (b < 'h80) begin
      if (mode == 2) begin
        pos = (pos < 255) ? pos + 1 : 255;
        emit(e_cs, pos, b);
      end else if (mode == 1) begin
        pos++;
        emit(e_cs, pos, b);
        if (pos == len) begin
          e_md = 1; pos = 0;
          if (syscom) begin pend = 1; mode = 0; end
        end
      end else bump();
    end else if (b == 'hF7) begin
      if (mode == 2) begin
        emit(e_cs, (pos < 255) ? pos + 1 : 255, b);
        e_md = 1; pend = 1; mode = 0; pos = 0;
      end else bump();
    end else begin
      if (mode == 2) bump();
      pos = 0;
      if (b == 'hF4 || b == 'hF5) begin
        bump(); e_cs = 0; mode = 0;
      end else if (b == 'hF6) begin
        emit(b, 0, b); e_md = 1; pend = 1; mode = 0;
      end else if (b == 'hF0) begin
        emit(b, 0, b); mode = 2;
      end else begin
        emit(b, 0, b);
        syscom = (b >= 'hF0);
        if ((b >= 'hC0 && b < 'hE0) || b == 'hF1 || b == 'hF3)
          len = 1;
        else
          len = 2;
        mode = 1;
      end
    end
  endtask

  task automatic check_all(string t);
    chk({t, ".br"}, byteready, e_br);
    chk({t, ".md"}, msg_done, e_md);
    chk({t, ".rv"}, rt_valid, e_rv);
    chk({t, ".rb"}, rt_byte, e_rb);
    chk({t, ".cs"}, cur_status, e_cs);
    chk({t, ".nr"}, midibyte_nr, e_nr);
    chk({t, ".dat"}, midi_in_data, e_dat);
    chk({t, ".sx"}, sysex_active, mode == 2);
    chk({t, ".err"}, err_count, err);
  endtask

  task automatic send(bit v, logic [7:0] b, string t);
    @(negedge clk);
    rx_valid = v;
    rx_byte = b;
    model_step(v, int'(b));
    @(posedge clk);
    #1;
    if (msg_done) md_seen++;
    check_all(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic seq(input logic [7:0] q[$], string t);
    foreach (q[i]) send(1'b1, q[i], t);
    send(1'b0, 8'h00, t);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("rst");
    do_reset();

    md_seen = 0;
    seq('{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00}, "s1");
    chk("s1.done", md_seen, 2);
    seq('{8'hC2, 8'h05, 8'h07}, "s2");
    seq('{8'h90, 8'hF8, 8'h3C, 8'hFA, 8'h64}, "s3");
    seq('{8'hF0, 8'h7E, 8'h01, 8'h02, 8'hF7}, "s4");
    chk("s4.cs", cur_status, 0);

    do_reset();
    seq('{8'h3C, 8'hF0, 8'h01, 8'h80, 8'hF5}, "s5");
    chk("s5.err", err_count, 3);

    do_reset();
    md_seen = 0;
    seq('{8'hF2, 8'h10, 8'h20, 8'h40}, "s6");
    chk("s6.err", err_count, 1);
    chk("s6.done", md_seen, 1);

    seq('{8'h90, 8'h3C}, "s7");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("s7.arst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 50)      b = 8'($urandom_range(0, 'h7F));
      else if (r < 78) b = 8'($urandom_range('h80, 'hEF));
      else if (r < 90) b = 8'($urandom_range('hF0, 'hF7));
      else             b = 8'($urandom_range('hF8, 'hFF));
      send($urandom_range(0, 3) != 0, b, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_byte_parser.md
# midi_byte_parser

Converts the raw received-byte stream of the MIDI UART receiver into framed message bytes with status, byte index and data, and drives the `byteready` / `cur_status` / `midibyte_nr` / `midi_in_data` bundle consumed by `midi_in_mux`. It sits directly between the receiver's byte output and the mux input.

It handles:
- running status;
- system-common length rules;
- SysEx framing;
- real-time bytes, which may be interleaved anywhere without disturbing framing.

## Interface
Parameters:
- `ERR_W`, default 8: width of the saturating framing-error counter.

Ports:
- `reg_clk`  in  1  system register clock; all logic on its rising edge.
- `reg_reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is a new received byte; back-to-back strobes allowed.
- `rx_byte`  in  8  received byte.
- `byteready`  out  1  one-cycle pulse: framed byte outputs updated.
- `cur_status`  out  8  status byte of the message in progress.
- `midibyte_nr`  out  8  index of the current byte within its message.
- `midi_in_data`  out  8  current byte value.
- `msg_done`  out  1  one-cycle pulse, coincident with `byteready`, on the last byte of a complete message.
- `rt_valid`  out  1  one-cycle pulse: real-time byte received.
- `rt_byte`  out  8  real-time byte value (F8..FF).
- `sysex_active`  out  1  high while inside F0..F7.
- `err_count`  out  `ERR_W`  saturating count of framing errors.

## Operation
States:
- **IDLE**: no running status.
- **DATA**: collecting data bytes; carries `need` (1 or 2) and `idx`.
- **SYSEX**: inside a SysEx message.

Byte classes and handling:
- **Real-time (F8..FF)**
  - Any state: `rt_valid`=1 and `rt_byte`=byte next cycle.
  - State, counters and `byteready` are untouched.
- **Channel status (80..EF)**
  - `need`=1 for Cx/Dx; `need`=2 otherwise.
  - `cur_status`=byte, `midibyte_nr`=0, `midi_in_data`=byte, `byteready` pulse; `idx`=0; next state DATA.
- **F0**
  - Same outputs as a status byte; next state SYSEX.
- **F1/F3** → `need`=1. **F2** → `need`=2.
  - Both emit as a status byte and go to DATA.
  - These do not establish running status.
- **F6**
  - Emits `byteready` and `msg_done` together, with `midibyte_nr`=0.
  - Then `cur_status`=00 and next state IDLE.
- **F4/F5**
  - No `byteready`; `err_count`++.
  - Next state IDLE; `cur_status`=00.
- **Data byte (00..7F)**
  - DATA: `idx`++, `midibyte_nr`=`idx`, `byteready` pulse.
  - On `idx`==`need`: `msg_done` pulse and `idx`←0.
    - Channel status: stay in DATA (running status); the next data byte restarts at `midibyte_nr`=1.
    - System common: `cur_status`←00 after the emitted byte, next state IDLE.
  - SYSEX: `idx` increments and saturates at 255; `byteready` pulse.
  - IDLE: byte dropped; `err_count`++.
- **F7**
  - In SYSEX: `byteready` + `msg_done` with `cur_status`=F0, `midi_in_data`=F7, `midibyte_nr`=`idx`+1 (saturating).
    - Then `cur_status`←00 and next state IDLE.
  - Outside SYSEX: dropped; `err_count`++.
- **Non-real-time status received in SYSEX**
  - Implicit termination; `err_count`++.
  - The new status is processed normally in the same cycle.

`err_count` saturates at 2^`ERR_W`-1.

## Timing
- Latency is 1 cycle: a byte strobed in cycle N produces outputs registered and visible in cycle N+1.
- `byteready`, `msg_done` and `rt_valid` are high for exactly one cycle each.
- `cur_status`, `midibyte_nr` and `midi_in_data` hold their values until the next `byteready`.
- No backpressure: every strobe is consumed, and a byte arriving every cycle is fully supported.
- At most one of `byteready` / `rt_valid` is high in any cycle.
- Reset values:
  - state IDLE;
  - all outputs 0;
  - `cur_status`=00, `idx`=0, `err_count`=0.
- A reset asserted mid-message aborts it without emitting `msg_done`. The first byte after reset must be a status byte; a leading data byte counts as an error.

## Structure
- The shared package `midi_pkg` holds:
  - the state enum (IDLE, DATA, SYSEX);
  - status constants: `ST_SYSEX`=F0, `ST_EOX`=F7, `ST_TUNE`=F6, `RT_MIN`=F8;
  - a function `data_len(status)` returning 0/1/2.
- The module is a single flat FSM with no sub-module.
- `midi_status` reuses the same package constants.

## Test plan
1. Bytes 90 3C 64 3C 00 → five `byteready` pulses with `midibyte_nr` 0,1,2,1,2 and `cur_status`=90; `msg_done` on the 3rd and 5th bytes.
2. Bytes C2 05 07 → `midibyte_nr` 0,1,1; `msg_done` on both data bytes; `cur_status` stays C2.
3. Bytes 90 F8 3C FA 64 → `rt_valid` pulses with rt_byte F8 and FA; note framing is identical to scenario 1, with no gap in `midibyte_nr`.
4. Bytes F0 7E 01 02 F7 → `midibyte_nr` 0..4; `msg_done` on F7; `sysex_active` 1→0 after F7; `cur_status`=00 afterwards.
5. Bytes 3C, F0 01 then 80, F5 → `err_count`=3; the first byte produces no `byteready`; 80 starts a new message with `sysex_active`=0.
6. Bytes F2 10 20 then 40 → `msg_done` on 20; 40 is dropped with `err_count`=1. A separate run asserting `reg_reset` mid-message clears every output to 0 in the same cycle.
